// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
//
// Owns the single write port of the LED output register. Two sources compete
// for it: direct CPU stores to the LED address, and an internal sequencer that
// rotates a 24-bit pattern by one bit every PERIOD cycles. CPU stores always
// win; a sequencer step that collides with a CPU store is held and issued on
// the next free cycle.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 LED     W: pass-through to the LED register. R: last led_wdata.
//   0x04 CTRL    RW: [0] EN, [1] DIR (0 left, 1 right), [31:16] STEP_LIMIT
//   0x08 PERIOD  RW: [PW-1:0] cycles per step (0 behaves as 1)
//   0x0C PATTERN RW: [23:0] seed / current pattern
//   0x10 STATUS  RO: [0] BUSY, [1] DONE (sticky), [31:16] STEP_CNT
//
// Handshake: cpu_we is a one-cycle store strobe qualified by cpu_addr and
// cpu_wdata, sampled on every rising clk edge; there is no back-pressure and
// every strobe is accepted. led_we is likewise a one-cycle strobe that the LED
// register block must accept in the cycle it is high. Reads are combinational
// on cpu_addr.
//
// Optional feature (macro LED_SEQ_BOUNCE_EN): after every 23 consecutive issued
// steps DIR toggles by itself, so a single lit bit walks end to end and back.
// CTRL[1] reads back the live direction; a CPU write to CTRL restarts the
// 23-step count. Without the macro DIR changes only by CPU write.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cpu_addr   CPU store/load address
//   cpu_we     CPU store strobe
//   cpu_wdata  CPU store data
//   cpu_rdata  register read data, 0 for unmapped addresses
//   led_we     LED register write strobe (registered)
//   led_addr   LED register address, BASE_ADDR whenever led_we=1 (registered)
//   led_wdata  LED register data, [31:24] always 0 (registered)
// -----------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFFF060,
    parameter int          PW        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        led_we,
    output logic [31:0] led_addr,
    output logic [31:0] led_wdata
);

    localparam logic [31:0] ADDR_LED     = BASE_ADDR;
    localparam logic [31:0] ADDR_CTRL    = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_PERIOD  = BASE_ADDR + 32'h8;
    localparam logic [31:0] ADDR_PATTERN = BASE_ADDR + 32'hC;
    localparam logic [31:0] ADDR_STATUS  = BASE_ADDR + 32'h10;

    localparam logic [PW-1:0] CNT_ZERO = '0;
    localparam logic [PW-1:0] CNT_ONE  = PW'(1);
    localparam logic [PW-1:0] CNT_TWO  = PW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          en_q, en_d;
    logic          dir_q, dir_d;
    logic [15:0]   limit_q, limit_d;
    logic [PW-1:0] period_q, period_d;
    logic [23:0]   pattern_q, pattern_d;
    logic          done_q, done_d;
    logic [15:0]   step_cnt_q, step_cnt_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          led_we_q, led_we_d;
    logic [31:0]   led_addr_q, led_addr_d;
    logic [23:0]   led_wdata_q, led_wdata_d;
`ifdef LED_SEQ_BOUNCE_EN
    logic [4:0]    bounce_q, bounce_d;
`endif

    logic          wr_led, wr_ctrl, wr_period, wr_pattern;
    logic [PW-1:0] first_load, next_load;
    logic [23:0]   pattern_rot;
    logic          last_step;

    assign wr_led     = cpu_we && (cpu_addr == ADDR_LED);
    assign wr_ctrl    = cpu_we && (cpu_addr == ADDR_CTRL);
    assign wr_period  = cpu_we && (cpu_addr == ADDR_PERIOD);
    assign wr_pattern = cpu_we && (cpu_addr == ADDR_PATTERN);

    // The first step after a start (or pattern reload) waits max(PERIOD,1)
    // counter cycles. After an issue the ISSUE cycle itself counts as one cycle
    // of the period, so steady-state strobes land exactly PERIOD cycles apart
    // (two cycles is the floor: one RUN cycle plus one ISSUE cycle).
    assign first_load = (period_q == CNT_ZERO) ? CNT_ZERO : period_q - CNT_ONE;
    assign next_load  = (period_q <= CNT_ONE)  ? CNT_ZERO : period_q - CNT_TWO;

    assign pattern_rot = dir_q ? {pattern_q[0], pattern_q[23:1]}
                               : {pattern_q[22:0], pattern_q[23]};

    assign last_step = (limit_q != 16'd0) && (step_cnt_q == limit_q);

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        dir_d       = dir_q;
        limit_d     = limit_q;
        period_d    = period_q;
        pattern_d   = pattern_q;
        done_d      = done_q;
        step_cnt_d  = step_cnt_q;
        cnt_d       = cnt_q;
        led_we_d    = 1'b0;
        led_addr_d  = led_addr_q;
        led_wdata_d = led_wdata_q;
`ifdef LED_SEQ_BOUNCE_EN
        bounce_d    = bounce_q;
`endif

        // CPU store to the LED address is passed through unconditionally.
        if (wr_led) begin
            led_we_d    = 1'b1;
            led_addr_d  = BASE_ADDR;
            led_wdata_d = cpu_wdata[23:0];
        end

        if ((state_q != IDLE) && wr_ctrl && !cpu_wdata[0]) begin
            // Stop: a pending issue is dropped, the pattern is kept as is.
            state_d = IDLE;
        end else if ((state_q != IDLE) && wr_pattern) begin
            // New seed while running beats this cycle's rotation/issue.
            cnt_d   = first_load;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_ctrl && cpu_wdata[0]) begin
                        cnt_d      = first_load;
                        step_cnt_d = 16'd0;
                        done_d     = 1'b0;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_ZERO) begin
                        pattern_d  = pattern_rot;
                        step_cnt_d = step_cnt_q + 16'd1;
                        state_d    = ISSUE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ISSUE: begin
                    // A CPU LED store this cycle owns the port; retry next cycle.
                    if (!wr_led) begin
                        led_we_d    = 1'b1;
                        led_addr_d  = BASE_ADDR;
                        led_wdata_d = pattern_q;
`ifdef LED_SEQ_BOUNCE_EN
                        if (bounce_q == 5'd22) begin
                            dir_d    = ~dir_q;
                            bounce_d = 5'd0;
                        end else begin
                            bounce_d = bounce_q + 5'd1;
                        end
`endif
                        if (last_step) begin
                            done_d  = 1'b1;
                            en_d    = 1'b0;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = next_load;
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // CPU field writes come last so an explicit store wins over the
        // sequencer's own updates of EN/DIR in the same cycle.
        if (wr_ctrl) begin
            en_d    = cpu_wdata[0];
            dir_d   = cpu_wdata[1];
            limit_d = cpu_wdata[31:16];
`ifdef LED_SEQ_BOUNCE_EN
            bounce_d = 5'd0;
`endif
        end
        if (wr_period) begin
            period_d = cpu_wdata[PW-1:0];
        end
        if (wr_pattern) begin
            pattern_d = cpu_wdata[23:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            dir_q       <= 1'b0;
            limit_q     <= 16'd0;
            period_q    <= '0;
            pattern_q   <= 24'd0;
            done_q      <= 1'b0;
            step_cnt_q  <= 16'd0;
            cnt_q       <= '0;
            led_we_q    <= 1'b0;
            led_addr_q  <= 32'd0;
            led_wdata_q <= 24'd0;
`ifdef LED_SEQ_BOUNCE_EN
            bounce_q    <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            dir_q       <= dir_d;
            limit_q     <= limit_d;
            period_q    <= period_d;
            pattern_q   <= pattern_d;
            done_q      <= done_d;
            step_cnt_q  <= step_cnt_d;
            cnt_q       <= cnt_d;
            led_we_q    <= led_we_d;
            led_addr_q  <= led_addr_d;
            led_wdata_q <= led_wdata_d;
`ifdef LED_SEQ_BOUNCE_EN
            bounce_q    <= bounce_d;
`endif
        end
    end

    always_comb begin
        cpu_rdata = 32'd0;
        case (cpu_addr)
            ADDR_LED:     cpu_rdata = {8'h00, led_wdata_q};
            ADDR_CTRL:    cpu_rdata = {limit_q, 14'd0, dir_q, en_q};
            ADDR_PERIOD:  cpu_rdata = 32'(period_q);
            ADDR_PATTERN: cpu_rdata = {8'h00, pattern_q};
            ADDR_STATUS:  cpu_rdata = {step_cnt_q, 14'd0, done_q, (state_q != IDLE)};
            default:      cpu_rdata = 32'd0;
        endcase
    end

    assign led_we    = led_we_q;
    assign led_addr  = led_addr_q;
    assign led_wdata = {8'h00, led_wdata_q};

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
//
// Self-checking bench for led_seq_ctrl. A monitor pops every LED strobe against
// an expected queue filled by a step-level model of the sequencer; scenario
// tasks check timing, register readback and corner cases inline.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

    localparam logic [31:0] BASE     = 32'hFFFFF060;
    localparam logic [31:0] A_LED    = BASE;
    localparam logic [31:0] A_CTRL   = BASE + 32'h4;
    localparam logic [31:0] A_PERIOD = BASE + 32'h8;
    localparam logic [31:0] A_PAT    = BASE + 32'hC;
    localparam logic [31:0] A_STATUS = BASE + 32'h10;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        led_we;
    logic [31:0] led_addr;
    logic [31:0] led_wdata;

    int          n_checks;
    int          n_fail;
    int          n_strobes;
    int          cyc;
    int          strobe_cyc[$];
    logic [31:0] exp_q[$];

    led_seq_ctrl #(.BASE_ADDR(BASE), .PW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .led_we    (led_we),
        .led_addr  (led_addr),
        .led_wdata (led_wdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && led_we) begin
            n_strobes++;
            strobe_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL led_strobe: unexpected write data=%h addr=%h at cycle %0d",
                         led_wdata, led_addr, cyc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (led_wdata !== e || led_addr !== BASE) begin
                    n_fail++;
                    $display("FAIL led_strobe: got data=%h addr=%h, required data=%h addr=%h",
                             led_wdata, led_addr, e, BASE);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // One sequencer step: rotate a 24-bit value by one place, with wrap.
    function automatic logic [23:0] model_rot(input logic [23:0] p, input logic d);
        int v;
        v = int'(p);
        if (!d) v = ((v * 2) % (1 << 24)) + (v / (1 << 23));
        else    v = (v / 2) + ((v % 2) * (1 << 23));
        return 24'(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(posedge clk);
        #1;
        cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        cpu_we   = 1'b0;
        cpu_addr = a;
        #1;
        d = cpu_rdata;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_strobes < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (n_strobes < target) begin
            n_fail++;
            $display("FAIL %s_timeout: strobes %0d, required %0d", name, n_strobes, target);
            exp_q.delete();
        end
    endtask

    // Start a run and check every step's value and timing plus final status.
    // Timing rule: first step max(P,1)+1 cycles after the start store, then one
    // step every max(P,2) cycles.
    task automatic run_seq(input logic [23:0] pat, input logic dir, input int per,
                           input int lim, input string name);
        logic [23:0] p;
        logic        d;
        logic [31:0] r;
        int          base, c0, m1, m2, exp_c;
        p = pat;
        d = dir;
        for (int i = 1; i <= lim; i++) begin
            p = model_rot(p, d);
            exp_q.push_back({8'h00, p});
`ifdef LED_SEQ_BOUNCE_EN
            if (i % 23 == 0) d = ~d;
`endif
        end
        m1 = (per < 1) ? 1 : per;
        m2 = (per < 2) ? 2 : per;
        base = n_strobes;
        cpu_write(A_PAT, {8'h00, pat});
        cpu_write(A_PERIOD, 32'(per));
        cpu_write(A_CTRL, {16'(lim), 14'd0, dir, 1'b1});
        c0 = cyc;
        wait_strobes(base + lim, (lim + 2) * (m2 + 2) + 20, name);
        for (int i = 0; i < lim; i++) begin
            exp_c = c0 + m1 + 1 + i * m2;
            n_checks++;
            if (strobe_cyc.size() <= base + i) begin
                n_fail++;
                $display("FAIL %s_timing: step %0d missing, required at cycle %0d", name, i + 1, exp_c);
            end else if (strobe_cyc[base + i] != exp_c) begin
                n_fail++;
                $display("FAIL %s_timing: step %0d at cycle %0d, required %0d",
                         name, i + 1, strobe_cyc[base + i], exp_c);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (n_strobes != base + lim) begin
            n_fail++;
            $display("FAIL %s_count: strobes %0d, required %0d", name, n_strobes - base, lim);
        end
        cpu_read(A_STATUS, r);
        n_checks++;
        if (r !== {16'(lim), 14'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL %s_status: got %h, required %h", name, r, {16'(lim), 14'd0, 2'b10});
        end
        cpu_read(A_CTRL, r);
        n_checks++;
        if (r !== {16'(lim), 14'd0, d, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_ctrl: got %h, required %h", name, r, {16'(lim), 14'd0, d, 1'b0});
        end
        cpu_read(A_PAT, r);
        n_checks++;
        if (r !== {8'h00, p}) begin
            n_fail++;
            $display("FAIL %s_pattern: got %h, required %h", name, r, {8'h00, p});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] r;
        n_checks++;
        if (led_we !== 1'b0 || led_addr !== 32'd0 || led_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h, required 0/0/0",
                     led_we, led_addr, led_wdata);
        end
        for (int i = 0; i < 5; i++) begin
            cpu_read(BASE + 32'(4 * i), r);
            n_checks++;
            if (r !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h, required 0", i, r);
            end
        end
    endtask

    task automatic test_regmap();
        logic [31:0] r;
        cpu_write(A_PERIOD, 32'h12345678);
        cpu_read(A_PERIOD, r);
        n_checks++;
        if (r !== 32'h12345678) begin
            n_fail++;
            $display("FAIL regmap_period: got %h, required 12345678", r);
        end
        cpu_write(A_CTRL, 32'hABCD0002);
        cpu_read(A_CTRL, r);
        n_checks++;
        if (r !== 32'hABCD0002) begin
            n_fail++;
            $display("FAIL regmap_ctrl: got %h, required abcd0002", r);
        end
        cpu_write(A_STATUS, 32'hFFFFFFFF);
        cpu_write(BASE + 32'h14, 32'hFFFFFFFF);
        cpu_read(A_STATUS, r);
        n_checks++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL regmap_status_ro: got %h, required 0", r);
        end
        cpu_read(BASE + 32'h14, r);
        n_checks++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL regmap_unmapped: got %h, required 0", r);
        end
        cpu_write(A_CTRL, 32'd0);
    endtask

    task automatic test_cpu_led();
        logic [31:0] r;
        exp_q.push_back(32'h00ABCDEF);
        cpu_write(A_LED, 32'h00ABCDEF);
        n_checks++;
        if (led_we !== 1'b1 || led_wdata !== 32'h00ABCDEF || led_addr !== BASE) begin
            n_fail++;
            $display("FAIL cpu_led_strobe: we=%b data=%h addr=%h, required 1/00abcdef/%h",
                     led_we, led_wdata, led_addr, BASE);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (led_we !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_led_single: we=%b, required 0", led_we);
        end
        cpu_read(A_LED, r);
        n_checks++;
        if (r !== 32'h00ABCDEF) begin
            n_fail++;
            $display("FAIL cpu_led_readback: got %h, required 00abcdef", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int          base, c0;
        base = n_strobes;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            d = $urandom();
            exp_q.push_back({8'h00, d[23:0]});
            cpu_write(A_LED, d);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (n_strobes != base + 8) begin
            n_fail++;
            $display("FAIL b2b_count: strobes %0d, required 8", n_strobes - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (strobe_cyc[base + i] != c0 + 1 + i) begin
                    n_fail++;
                    $display("FAIL b2b_timing: write %0d at cycle %0d, required %0d",
                             i, strobe_cyc[base + i], c0 + 1 + i);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] r;
        int          base, c0;
        base = n_strobes;
        cpu_write(A_PAT, 32'h000001);
        cpu_write(A_PERIOD, 32'd4);
        exp_q.push_back(32'h00000055);
        exp_q.push_back(32'h00000002);
        cpu_write(A_CTRL, 32'h00010001);
        c0 = cyc;
        repeat (4) @(posedge clk);
        #1;
        cpu_write(A_LED, 32'h00000055);
        wait_strobes(base + 2, 20, "collision");
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (n_strobes != base + 2) begin
            n_fail++;
            $display("FAIL collision_count: strobes %0d, required 2", n_strobes - base);
        end else begin
            n_checks++;
            if (strobe_cyc[base] != c0 + 5 || strobe_cyc[base + 1] != c0 + 6) begin
                n_fail++;
                $display("FAIL collision_timing: cycles %0d,%0d, required %0d,%0d",
                         strobe_cyc[base], strobe_cyc[base + 1], c0 + 5, c0 + 6);
            end
        end
        cpu_read(A_STATUS, r);
        n_checks++;
        if (r !== 32'h00010002) begin
            n_fail++;
            $display("FAIL collision_status: got %h, required 00010002", r);
        end
    endtask

    task automatic test_stop();
        logic [31:0] r;
        int          base;
        base = n_strobes;
        cpu_write(A_PAT, 32'h000001);
        cpu_write(A_PERIOD, 32'd8);
        exp_q.push_back(32'h00000002);
        exp_q.push_back(32'h00000004);
        cpu_write(A_CTRL, 32'h00000001);
        wait_strobes(base + 2, 60, "stop");
        cpu_write(A_CTRL, 32'h00000000);
        cpu_read(A_STATUS, r);
        n_checks++;
        if (r !== 32'h00020000) begin
            n_fail++;
            $display("FAIL stop_status: got %h, required 00020000", r);
        end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (n_strobes != base + 2) begin
            n_fail++;
            $display("FAIL stop_quiet: strobes %0d, required 2", n_strobes - base);
        end
        cpu_read(A_PAT, r);
        n_checks++;
        if (r !== 32'h00000004) begin
            n_fail++;
            $display("FAIL stop_pattern: got %h, required 00000004", r);
        end
    endtask

    task automatic test_random_runs();
        logic [23:0] pat;
        logic        dir;
        int          per, lim;
        for (int i = 0; i < 6; i++) begin
            pat = 24'($urandom());
            dir = 1'($urandom_range(0, 1));
            per = $urandom_range(0, 6);
            lim = $urandom_range(1, 5);
            run_seq(pat, dir, per, lim, "random_run");
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int          base;
        base = n_strobes;
        cpu_write(A_PAT, 32'h000123);
        cpu_write(A_PERIOD, 32'd3);
        cpu_write(A_CTRL, 32'h00000001);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led_we !== 1'b0 || led_addr !== 32'd0 || led_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: we=%b addr=%h data=%h, required 0/0/0",
                     led_we, led_addr, led_wdata);
        end
        for (int i = 0; i < 5; i++) begin
            cpu_read(BASE + 32'(4 * i), r);
            n_checks++;
            if (r !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mid_reg%0d: got %h, required 0", i, r);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (n_strobes != base) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: strobes %0d, required 0", n_strobes - base);
        end
    endtask

`ifdef LED_SEQ_BOUNCE_EN
    task automatic test_bounce();
        run_seq(24'h000001, 1'b0, 1, 46, "bounce");
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_strobes = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_regmap();
        test_cpu_led();
        test_back_to_back();
        run_seq(24'h000001, 1'b0, 4, 3, "seq_left");
        run_seq(24'h000001, 1'b1, 0, 1, "seq_period0");
        test_collision();
        test_stop();
        test_random_runs();
        test_reset_mid();
`ifdef LED_SEQ_BOUNCE_EN
        test_bounce();
`endif
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
